imem_loader: RTL
================

# imem_loader

Streams an instruction image into the 12-bit-addressed instruction ROM/RAM that the processor fetches from. It holds the CPU in reset while loading, then releases it. It accepts a byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit words, and issues one write per word at consecutive addresses from 0. The block sits beside `processor` in `Wrapper`. It is the writer for the instruction memory the CPU only reads.

## Interface
- `ADDR_WIDTH`, 12: instruction memory address width.
- `DEPTH`, 4096: maximum words loadable; must equal 2^ADDR_WIDTH.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; **one clock; reset is synchronous and active-high**.
- `start` in 1: one-cycle pulse that begins a load; sampled only in IDLE or DONE.
- `word_count` in ADDR_WIDTH+1: words to load; sampled on the accepted `start`; values > DEPTH clamp to DEPTH.
- `byte_valid` in 1, `byte_data` in 8: source byte stream.
- `byte_ready` out 1: loader can accept a byte this cycle.
- `imem_wEn` out 1, `imem_addr` out ADDR_WIDTH, `imem_dataIn` out 32: write port to instruction memory.
- `cpu_reset` out 1: hold the processor in reset; OR externally with board reset.
- `busy` out 1, `done` out 1: status.
- `err` out 1: checksum mismatch; exists only with the checksum macro.

## Operation
- States: IDLE, LOAD, CHECK (checksum builds only), FINISH, DONE.
- IDLE/DONE with `start`:
  - latch `word_count`; clear address, byte index, running sum, `done`, `err`.
  - go to LOAD; if count is 0, go to CHECK (or FINISH when checksum is disabled).
- LOAD: `byte_ready`=1. An accepted byte (`byte_valid & byte_ready`) fills lane `idx` (byte 0 → [7:0]) and sets `idx` = `idx`+1 mod 4.
  - On the 4th byte, register word/address, pulse `imem_wEn` for exactly one cycle next cycle, increment address, add the word to the sum (32-bit, wraps).
  - After the last word's 4th byte, go to CHECK (or FINISH).
- CHECK: accept 4 more bytes as the expected sum. `err`=1 if it differs from the running sum; no memory write. Then go to FINISH.
- FINISH: one cycle, `byte_ready`=0; then go to DONE.
- DONE: `done`=1, `busy`=0. `cpu_reset`=0, or stays 1 if `err`.
- `busy`=1 and `cpu_reset`=1 in LOAD, CHECK and FINISH.
- `start` during LOAD/CHECK/FINISH is ignored.
- `byte_valid` outside LOAD/CHECK: not accepted, no effect.
- Address never exceeds DEPTH-1; clamping guarantees no wrap.
- `reset` mid-load:
  - next state IDLE; partial word discarded; no further writes.
  - words already written stay in memory.
  - `cpu_reset` drops to 0.

## Timing
- Reset values: state IDLE; `byte_ready`, `imem_wEn`, `busy`, `done`, `err`, `cpu_reset` = 0; `imem_addr` = 0; `imem_dataIn` = 0.
- Accepted `start` at edge t → LOAD, `busy`/`cpu_reset`/`byte_ready` high from cycle t+1.
- 4th byte of word N accepted at edge t → `imem_wEn`=1 with `imem_addr`=N during cycle t+1 only.
- Throughput: one byte per cycle, no stall between words.
- Last byte accepted at edge t (final word, or final checksum byte):
  - FINISH in cycle t+1; the final `imem_wEn` pulse lands here.
  - DONE from cycle t+2: `done`=1, `cpu_reset`=0.
- `done` holds until the next accepted `start` or `reset`.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - CHECK state, running sum and `err` port are present.
  - a failed load leaves `cpu_reset`=1 until the next successful load or `reset`.
- Undefined: no CHECK state and no `err` port; LOAD goes directly to FINISH; the stream is exactly 4×`word_count` bytes.

## Structure
- `imem_loader_pkg`: state enum, `BYTES_PER_WORD`=4, default widths.
- One sub-module, `byte_packer`:
  - inputs: byte, accept, clear.
  - outputs: 32-bit word, `word_ready` pulse.
  - used for both image words and the checksum word.

## Test plan
- Load 2 words, bytes 0x11,0x22,0x33,0x44,0xAA,0xBB,0xCC,0xDD, valid every cycle:
  - writes 0x44332211@0 and 0xDDCCBBAA@1, one-cycle strobes;
  - `done` 2 cycles after the last byte; `cpu_reset` low.
- Same load with `byte_valid` toggling every other cycle → identical writes, no duplicate or dropped bytes.
- `word_count`=0 → no `imem_wEn` pulse; `done` high 2 cycles after `start` (no checksum); with checksum, after 4 zero bytes.
- `reset` after 5 bytes of a 3-word load:
  - word 0 written, nothing after;
  - outputs at reset values;
  - a new 1-word load then writes address 0.
- With checksum, 1 word 0x00000005 then checksum 0x00000006 → `err`=1, `cpu_reset`=1, `done`=1; reload with checksum 0x00000005 → `err`=0, `cpu_reset`=0.
- `word_count`=5000 → exactly 4096 writes, addresses 0..4095, no wrap; `start` pulsed mid-load is ignored.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// IMEM_LOADER_CHECKSUM_EN adds the trailing checksum word and its CHECK state.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_WIDTH     = 32;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_DEPTH      = 4096;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK  = 3'd2,
`endif
        S_FINISH = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    // Where the image phase hands over once the last word is in.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e S_POST_LOAD = S_CHECK;
`else
    localparam state_e S_POST_LOAD = S_FINISH;
`endif

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes little-endian into words; word_ready_o fires with the
// final byte so the full word is usable in the same cycle.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            byte_i,
    input  logic                  accept_i,
    input  logic                  clear_i,
    output logic [WORD_WIDTH-1:0] word_o,
    output logic                  word_ready_o
);

    localparam int IDX_W  = $clog2(BYTES_PER_WORD);
    localparam int LANE_W = (BYTES_PER_WORD - 1) * 8;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES_PER_WORD - 1);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LANE_W-1:0] lanes_q, lanes_d;

    always_comb begin
        idx_d   = idx_q;
        lanes_d = lanes_q;
        if (clear_i) begin
            idx_d   = '0;
            lanes_d = '0;
        end else if (accept_i) begin
            idx_d = idx_q + 1'b1;
            if (idx_q != LAST) begin
                lanes_d[idx_q*8 +: 8] = byte_i;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q   <= '0;
            lanes_q <= '0;
        end else begin
            idx_q   <= idx_d;
            lanes_q <= lanes_d;
        end
    end

    assign word_o       = {byte_i, lanes_q};
    assign word_ready_o = accept_i & ~clear_i & (idx_q == LAST);

endmodule

// File: rtl/imem_loader.sv
// Streams a byte image into instruction memory while holding the CPU in reset.
// IMEM_LOADER_CHECKSUM_EN appends a checksum word and exposes err.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  imem_wEn,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [WORD_WIDTH-1:0] imem_dataIn,
    output logic                  cpu_reset,
    output logic                  busy,
`ifdef IMEM_LOADER_CHECKSUM_EN
    output logic                  done,
    output logic                  err
`else
    output logic                  done
`endif
);

    localparam int CW = ADDR_WIDTH + 1;

    state_e                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [CW-1:0]         words_q, words_d;
    logic                  wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;

    logic                  accept;
    logic                  pk_clear;
    logic                  pk_ready;
    logic [WORD_WIDTH-1:0] pk_word;
    logic [CW-1:0]         clamped;
    logic [CW-1:0]         words_inc;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] sum_q, sum_d;
    logic                  err_q, err_d;
`endif

    assign accept    = byte_valid & byte_ready;
    assign clamped   = (word_count > CW'(DEPTH)) ? CW'(DEPTH) : word_count;
    assign words_inc = words_q + 1'b1;

    byte_packer u_packer (
        .clock        (clock),
        .reset        (reset),
        .byte_i       (byte_data),
        .accept_i     (accept),
        .clear_i      (pk_clear),
        .word_o       (pk_word),
        .word_ready_o (pk_ready)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        words_d  = words_q;
        wen_d    = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        pk_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    count_d  = clamped;
                    words_d  = '0;
                    waddr_d  = '0;
                    pk_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d    = '0;
                    err_d    = 1'b0;
`endif
                    state_d  = (clamped == '0) ? S_POST_LOAD : S_LOAD;
                end
            end
            S_LOAD: begin
                if (pk_ready) begin
                    wen_d   = 1'b1;
                    waddr_d = words_q[ADDR_WIDTH-1:0];
                    wdata_d = pk_word;
                    words_d = words_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + pk_word;
`endif
                    if (words_inc == count_q) begin
                        state_d = S_POST_LOAD;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (pk_ready) begin
                    err_d   = (pk_word != sum_q);
                    state_d = S_FINISH;
                end
            end
`endif
            S_FINISH: state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            words_q <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            words_q <= words_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

    assign imem_wEn    = wen_q;
    assign imem_addr   = waddr_q;
    assign imem_dataIn = wdata_q;
    assign done        = (state_q == S_DONE);

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign byte_ready = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign busy       = byte_ready || (state_q == S_FINISH);
    assign err        = err_q;
    // A failed checksum keeps the CPU parked even after the loader is done.
    assign cpu_reset  = busy | (done & err_q);
`else
    assign byte_ready = (state_q == S_LOAD);
    assign busy       = byte_ready || (state_q == S_FINISH);
    assign cpu_reset  = busy;
`endif

endmodule
